// File: rtl/freecell_move_sequencer.sv
// Move stream source for freecellPlayer: buffers two-character moves in a FIFO,
// encodes them at pop time and presents one per clock until the player wins.
module freecell_move_sequencer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_move,
   input  logic        start,
   input  logic        win,
   output logic [3:0]  source,
   output logic [3:0]  dest,
   output logic        move_valid,
   output logic        running,
   output logic        won,
   output logic [7:0]  moves_issued,
   output logic [7:0]  bad_moves
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [3:0]        NOP_CODE = 4'hF;

   // Returns {malformed, code}; malformed characters map to the no-op code.
   function automatic logic [4:0] enc_char(input logic [7:0] c);
      logic [4:0] r;
      case (c) inside
         [8'h31:8'h38]: r = {1'b0, c[3:0] - 4'd1};
         [8'h61:8'h64]: r = {1'b0, c[3:0] + 4'd7};
         8'h68:         r = {1'b0, 4'd12};
         default:       r = {1'b1, NOP_CODE};
      endcase
      return r;
   endfunction

   state_t            state_r;
   state_t            state_s;
   logic [15:0]       mem_r [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic              full_s;
   logic              empty_s;
   logic              push_s;
   logic              pop_s;
   logic [15:0]       rd_word_s;
   logic [4:0]        src_enc_s;
   logic [4:0]        dst_enc_s;
   logic              bad_s;

   logic [3:0]        source_r;
   logic [3:0]        dest_r;
   logic              move_valid_r;
   logic              running_r;
   logic              won_r;
   logic [7:0]        moves_issued_r;
   logic [7:0]        bad_moves_r;

   assign full_s  = (count_r == FULL_CNT);
   assign empty_s = (count_r == '0);
   // Writes in DONE are handshaken but dropped.
   assign push_s  = in_valid && !full_s && (state_r != ST_DONE);

   // Next-state and pop decision.
   always_comb begin
      state_s = state_r;
      pop_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (win) begin
               state_s = ST_DONE;
            end else if (!empty_s) begin
               pop_s = 1'b1;
            end else begin
               pop_s = 1'b0;
            end
         end
         ST_DONE: state_s = ST_DONE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Decode of the head entry; only consumed when pop_s is high.
   always_comb begin
      rd_word_s = mem_r[rd_ptr_r];
      src_enc_s = enc_char(rd_word_s[15:8]);
      dst_enc_s = enc_char(rd_word_s[7:0]);
      bad_s     = src_enc_s[4] | dst_enc_s[4];
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clock) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_move;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Registered move presentation, status flags and saturating counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         source_r       <= NOP_CODE;
         dest_r         <= NOP_CODE;
         move_valid_r   <= 1'b0;
         running_r      <= 1'b0;
         won_r          <= 1'b0;
         moves_issued_r <= 8'd0;
         bad_moves_r    <= 8'd0;
      end else begin
         if (pop_s && !bad_s) begin
            source_r     <= src_enc_s[3:0];
            dest_r       <= dst_enc_s[3:0];
            move_valid_r <= 1'b1;
            if (moves_issued_r != 8'hFF) begin
               moves_issued_r <= moves_issued_r + 8'd1;
            end
         end else if (pop_s) begin
            source_r     <= NOP_CODE;
            dest_r       <= NOP_CODE;
            move_valid_r <= 1'b0;
            if (bad_moves_r != 8'hFF) begin
               bad_moves_r <= bad_moves_r + 8'd1;
            end
         end else begin
            source_r     <= NOP_CODE;
            dest_r       <= NOP_CODE;
            move_valid_r <= 1'b0;
         end
         running_r <= (state_s == ST_RUN);
         won_r     <= (state_s == ST_DONE);
      end
   end

   assign in_ready     = !full_s;
   assign source       = source_r;
   assign dest         = dest_r;
   assign move_valid   = move_valid_r;
   assign running      = running_r;
   assign won          = won_r;
   assign moves_issued = moves_issued_r;
   assign bad_moves    = bad_moves_r;

endmodule
